// File: rtl/dbus_gpio_timer_if.sv
// dBus peripheral port: single-cycle command, read data returned one cycle later.
interface dbus_gpio_timer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic [1:0]  cmd_size;
  logic        rsp_ready;
  logic        rsp_error;
  logic [31:0] rsp_data;

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_data, cmd_size,
    input  cmd_ready, rsp_ready, rsp_error, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_data, cmd_size,
    output cmd_ready, rsp_ready, rsp_error, rsp_data
  );
endinterface

// File: rtl/dbus_gpio_timer.sv
// GPIO out/in banks with rising-edge capture and a prescaled compare-match timer,
// exposed as a zero-wait-state dBus slave with one-cycle read latency.

// One GPIO input: 2-FF synchroniser, primed edge detector, sticky rise flag.
module dbus_gpio_timer_lane (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  input  logic w1c,
  output logic sync_o,
  output logic rise_o,
  output logic rise_nxt_o
);
  logic sync1_q, sync1_d, sync2_q, sync2_d;
  logic prev_q, prev_d, primed_q, primed_d, rise_q, rise_d;

  // The first sample after reset only primes prev; a same-cycle edge beats W1C.
  always_comb begin
    sync1_d  = pin;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    primed_d = 1'b1;
    rise_d   = (rise_q & ~w1c) | (primed_q & sync2_q & ~prev_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      primed_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      primed_q <= primed_d;
      rise_q   <= rise_d;
    end
  end

  assign sync_o     = sync2_q;
  assign rise_o     = rise_q;
  assign rise_nxt_o = rise_d;
endmodule

module dbus_gpio_timer #(
  parameter int                 NUM_OUT    = 3,
  parameter int                 NUM_IN     = 1,
  parameter logic [NUM_OUT-1:0] OUT_INVERT = 3'b111,
  parameter logic [NUM_OUT-1:0] OUT_RESET  = '0,
  parameter int                 TIMER_BITS = 32,
  parameter bit                 SIM_FLAG   = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  dbus_gpio_timer_if.slave      bus,
  output logic [NUM_OUT-1:0]    gpio_out,
  input  logic [NUM_IN-1:0]     gpio_in,
  output logic                  timer_irq,
  output logic                  gpio_irq
);
  localparam logic [5:0] R_OUT  = 6'd0;
  localparam logic [5:0] R_SET  = 6'd1;
  localparam logic [5:0] R_CLR  = 6'd2;
  localparam logic [5:0] R_IN   = 6'd3;
  localparam logic [5:0] R_RISE = 6'd4;
  localparam logic [5:0] R_IEN  = 6'd5;
  localparam logic [5:0] R_CTRL = 6'd6;
  localparam logic [5:0] R_CMP  = 6'd7;
  localparam logic [5:0] R_CNT  = 6'd8;
  localparam logic [5:0] R_ID   = 6'd9;

  logic [5:0]  idx;
  logic        rd_en, wr_en;
  logic [3:0]  be;
  logic [31:0] wmask, wdat;

  logic [NUM_OUT-1:0]    out_q, out_d, gpio_out_q, gpio_out_d;
  logic [NUM_IN-1:0]     ien_q, ien_d;
  logic [NUM_IN-1:0]     in_sync, in_rise, in_rise_nxt, rise_w1c;
  logic                  en_q, en_d, ar_q, ar_d, ie_q, ie_d, pend_q, pend_d;
  logic [7:0]            p_q, p_d, psc_q, psc_d;
  logic [TIMER_BITS-1:0] cmp_q, cmp_d, cnt_q, cnt_d;
  logic                  tick, match;
  logic                  timer_irq_q, timer_irq_d, gpio_irq_q, gpio_irq_d;
  logic                  rsp_ready_q, rsp_ready_d, rsp_error_q, rsp_error_d;
  logic [31:0]           rsp_data_q, rsp_data_d, rd_val;
  logic                  rd_err;

  assign idx   = bus.cmd_addr[7:2];
  assign rd_en = bus.cmd_valid & ~bus.cmd_wr;
  assign wr_en = bus.cmd_valid & bus.cmd_wr;

  always_comb begin
    case (bus.cmd_size)
      2'd0:    be = 4'b0001 << bus.cmd_addr[1:0];
      2'd1:    be = 4'b0011 << bus.cmd_addr[1:0];
      default: be = 4'b1111;
    endcase
    wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    wdat  = bus.cmd_data & wmask;
  end

  assign rise_w1c = (wr_en && idx == R_RISE) ? wdat[NUM_IN-1:0] : '0;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    dbus_gpio_timer_lane u_lane (
      .clk        (clk),
      .reset      (reset),
      .pin        (gpio_in[i]),
      .w1c        (rise_w1c[i]),
      .sync_o     (in_sync[i]),
      .rise_o     (in_rise[i]),
      .rise_nxt_o (in_rise_nxt[i])
    );
  end

  // Read mux sees pre-update state; unmapped offsets flag an error.
  always_comb begin
    rd_val = '0;
    rd_err = 1'b0;
    case (idx)
      R_OUT:        rd_val = 32'(out_q);
      R_SET, R_CLR: rd_val = '0;
      R_IN:         rd_val = 32'(in_sync);
      R_RISE:       rd_val = 32'(in_rise);
      R_IEN:        rd_val = 32'(ien_q);
      R_CTRL:       rd_val = {8'b0, p_q, 7'b0, pend_q, 5'b0, ie_q, ar_q, en_q};
      R_CMP:        rd_val = 32'(cmp_q);
      R_CNT:        rd_val = 32'(cnt_q);
      R_ID:         rd_val = {8'(NUM_OUT), 8'(NUM_IN), 8'(TIMER_BITS), 7'b0, SIM_FLAG};
      default:      rd_err = 1'b1;
    endcase
    rsp_ready_d = rd_en;
    rsp_data_d  = rd_en ? rd_val : '0;
    rsp_error_d = rd_en & rd_err;
  end

  always_comb begin
    out_d = out_q;
    if (wr_en && idx == R_OUT) out_d = (out_q & ~wmask[NUM_OUT-1:0]) | wdat[NUM_OUT-1:0];
    if (wr_en && idx == R_SET) out_d = out_q | wdat[NUM_OUT-1:0];
    if (wr_en && idx == R_CLR) out_d = out_q & ~wdat[NUM_OUT-1:0];
    gpio_out_d = out_d ^ OUT_INVERT;

    ien_d = ien_q;
    if (wr_en && idx == R_IEN) ien_d = (ien_q & ~wmask[NUM_IN-1:0]) | wdat[NUM_IN-1:0];
    gpio_irq_d = |(in_rise_nxt & ien_d);
  end

  // Timer: CPU CNT writes override the tick update, match still sets pending.
  always_comb begin
    tick  = en_q && (psc_q == p_q);
    match = tick && (cnt_q == cmp_q);
    psc_d = (!en_q || tick) ? 8'd0 : psc_q + 8'd1;
    cnt_d = match ? '0 : (tick ? cnt_q + TIMER_BITS'(1) : cnt_q);
    en_d  = (match && !ar_q) ? 1'b0 : en_q;
    ar_d  = ar_q;
    ie_d  = ie_q;
    p_d   = p_q;
    pend_d = pend_q;
    cmp_d = cmp_q;
    if (wr_en && idx == R_CTRL) begin
      if (be[0]) begin
        en_d = bus.cmd_data[0];
        ar_d = bus.cmd_data[1];
        ie_d = bus.cmd_data[2];
      end
      if (be[1] && bus.cmd_data[8]) pend_d = 1'b0;
      if (be[2]) p_d = bus.cmd_data[23:16];
    end
    if (match) pend_d = 1'b1;
    if (wr_en && idx == R_CMP)
      cmp_d = (cmp_q & ~wmask[TIMER_BITS-1:0]) | wdat[TIMER_BITS-1:0];
    if (wr_en && idx == R_CNT)
      cnt_d = (cnt_q & ~wmask[TIMER_BITS-1:0]) | wdat[TIMER_BITS-1:0];
    timer_irq_d = pend_d & ie_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q       <= OUT_RESET;
      gpio_out_q  <= OUT_RESET ^ OUT_INVERT;
      ien_q       <= '0;
      en_q        <= 1'b0;
      ar_q        <= 1'b0;
      ie_q        <= 1'b0;
      pend_q      <= 1'b0;
      p_q         <= '0;
      psc_q       <= '0;
      cmp_q       <= '0;
      cnt_q       <= '0;
      timer_irq_q <= 1'b0;
      gpio_irq_q  <= 1'b0;
      rsp_ready_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      out_q       <= out_d;
      gpio_out_q  <= gpio_out_d;
      ien_q       <= ien_d;
      en_q        <= en_d;
      ar_q        <= ar_d;
      ie_q        <= ie_d;
      pend_q      <= pend_d;
      p_q         <= p_d;
      psc_q       <= psc_d;
      cmp_q       <= cmp_d;
      cnt_q       <= cnt_d;
      timer_irq_q <= timer_irq_d;
      gpio_irq_q  <= gpio_irq_d;
      rsp_ready_q <= rsp_ready_d;
      rsp_error_q <= rsp_error_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.cmd_ready = 1'b1;
  assign bus.rsp_ready = rsp_ready_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.rsp_data  = rsp_data_q;
  assign gpio_out      = gpio_out_q;
  assign timer_irq     = timer_irq_q;
  assign gpio_irq      = gpio_irq_q;
endmodule

// File: tb/tb_dbus_gpio_timer.sv
// Directed + random bench for dbus_gpio_timer against a cycle-level register model.
module tb_dbus_gpio_timer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] gpio_out;
  logic [0:0] gpio_in;
  logic       timer_irq, gpio_irq;
  int         errors = 0;
  int         checks = 0;

  dbus_gpio_timer_if bus ();

  dbus_gpio_timer dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .gpio_out  (gpio_out),
    .gpio_in   (gpio_in),
    .timer_irq (timer_irq),
    .gpio_irq  (gpio_irq)
  );

  always #5 clk = ~clk;

  // Reference state, named after the programmer-visible registers.
  logic [2:0]  m_out;
  logic        m_s1, m_s2, m_prev, m_primed, m_rise, m_ien;
  logic        m_en, m_ar, m_ie, m_pend;
  logic [7:0]  m_p, m_psc;
  logic [31:0] m_cmp, m_cnt;
  logic        m_rdy, m_err;
  logic [31:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_out = 3'd0; m_s1 = 0; m_s2 = 0; m_prev = 0; m_primed = 0; m_rise = 0; m_ien = 0;
    m_en = 0; m_ar = 0; m_ie = 0; m_pend = 0; m_p = 0; m_psc = 0; m_cmp = 0; m_cnt = 0;
    m_rdy = 0; m_err = 0; m_data = 0;
  endtask

  function automatic logic [32:0] reg_read(input logic [7:0] a);
    case (a[7:2])
      0:       return {1'b0, 29'd0, m_out};
      1, 2:    return 33'd0;
      3:       return {1'b0, 31'd0, m_s2};
      4:       return {1'b0, 31'd0, m_rise};
      5:       return {1'b0, 31'd0, m_ien};
      6:       return {1'b0, 8'd0, m_p, 7'd0, m_pend, 5'd0, m_ie, m_ar, m_en};
      7:       return {1'b0, m_cmp};
      8:       return {1'b0, m_cnt};
      9:       return {1'b0, 32'h0301_2000};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_edge();
    logic [3:0]  be;
    logic [31:0] msk, d;
    logic        tick, match, new_edge, wr, n_en, n_pend, n_rise;
    logic [7:0]  n_psc;
    logic [31:0] n_cnt;
    m_rdy = bus.cmd_valid && !bus.cmd_wr;
    {m_err, m_data} = m_rdy ? reg_read(bus.cmd_addr) : 33'd0;
    case (bus.cmd_size)
      2'd0:    be = 4'b0001 << bus.cmd_addr[1:0];
      2'd1:    be = 4'b0011 << bus.cmd_addr[1:0];
      default: be = 4'b1111;
    endcase
    for (int b = 0; b < 4; b++) msk[b*8 +: 8] = {8{be[b]}};
    d = bus.cmd_data & msk;
    wr = bus.cmd_valid && bus.cmd_wr;
    new_edge = m_primed && m_s2 && !m_prev;
    tick  = m_en && (m_psc == m_p);
    match = tick && (m_cnt == m_cmp);
    n_psc = (!m_en || tick) ? 8'd0 : m_psc + 8'd1;
    n_cnt = match ? 32'd0 : (tick ? m_cnt + 32'd1 : m_cnt);
    n_en  = (match && !m_ar) ? 1'b0 : m_en;
    n_pend = m_pend;
    n_rise = m_rise;
    if (wr) begin
      case (bus.cmd_addr[7:2])
        0: m_out = (m_out & ~msk[2:0]) | d[2:0];
        1: m_out = m_out | d[2:0];
        2: m_out = m_out & ~d[2:0];
        4: n_rise = n_rise & ~d[0];
        5: m_ien = (m_ien & ~msk[0]) | d[0];
        6: begin
          if (be[0]) begin n_en = d[0]; m_ar = d[1]; m_ie = d[2]; end
          if (d[8]) n_pend = 1'b0;
          if (be[2]) m_p = d[23:16];
        end
        7: m_cmp = (m_cmp & ~msk) | d;
        8: n_cnt = (m_cnt & ~msk) | d;
        default: ;
      endcase
    end
    if (new_edge) n_rise = 1'b1;
    if (match) n_pend = 1'b1;
    m_prev = m_s2; m_s2 = m_s1; m_s1 = gpio_in[0]; m_primed = 1'b1;
    m_rise = n_rise; m_psc = n_psc; m_cnt = n_cnt; m_en = n_en; m_pend = n_pend;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("rsp_ready", 32'(bus.rsp_ready), 32'(m_rdy));
    if (m_rdy) begin
      chk("rsp_data", bus.rsp_data, m_data);
      chk("rsp_error", 32'(bus.rsp_error), 32'(m_err));
    end
    chk("gpio_out", 32'(gpio_out), 32'(m_out ^ 3'b111));
    chk("timer_irq", 32'(timer_irq), 32'(m_pend & m_ie));
    chk("gpio_irq", 32'(gpio_irq), 32'(m_rise & m_ien));
  endtask

  task automatic idle();
    bus.cmd_valid = 1'b0;
    step();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] dat, input logic [1:0] sz = 2'd2);
    bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_addr = a;
    bus.cmd_data = dat; bus.cmd_size = sz;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] dat);
    bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b0; bus.cmd_addr = a;
    bus.cmd_data = $urandom; bus.cmd_size = 2'd2;
    step();
    bus.cmd_valid = 1'b0;
    dat = bus.rsp_data;
  endtask

  initial begin
    logic [31:0] v;
    int n;
    bus.cmd_valid = 0; bus.cmd_wr = 0; bus.cmd_addr = 0; bus.cmd_data = 0; bus.cmd_size = 2;
    gpio_in = 1'b0;
    m_reset();
    #12;
    chk("reset_gpio_out", 32'(gpio_out), 32'h7);
    chk("reset_rsp_ready", 32'(bus.rsp_ready), 32'h0);
    chk("reset_irqs", {30'd0, timer_irq, gpio_irq}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    rd(8'h24, v);
    chk("id_value", v, 32'h0301_2000);
    chk("id_error", 32'(bus.rsp_error), 32'h0);

    wr(8'h00, 32'h5);
    wr(8'h08, 32'h4);
    wr(8'h04, 32'h2);
    rd(8'h00, v);
    chk("out_set_clr", v, 32'h3);
    chk("out_pins", 32'(gpio_out), 32'h4);
    wr(8'h01, 32'hFFFF_FFFF, 2'd0);
    rd(8'h00, v);
    chk("out_byte_lane", v, 32'h3);

    gpio_in = 1'b1;
    repeat (4) idle();
    rd(8'h10, v);
    chk("rise_flag", v, 32'h1);
    chk("gpio_irq_masked", 32'(gpio_irq), 32'h0);
    wr(8'h14, 32'h1);
    chk("gpio_irq_enabled", 32'(gpio_irq), 32'h1);
    wr(8'h10, 32'h1);
    chk("rise_w1c", 32'(gpio_irq), 32'h0);
    gpio_in = 1'b0;
    repeat (4) idle();
    gpio_in = 1'b1;
    idle();
    idle();
    wr(8'h10, 32'h1);
    chk("edge_beats_w1c", 32'(gpio_irq), 32'h1);
    wr(8'h10, 32'h1);
    wr(8'h14, 32'h0);

    wr(8'h1C, 32'd3);
    wr(8'h18, 32'h0001_0007);
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      idle();
      if (timer_irq) n = i;
    end
    chk("timer_match_latency", 32'(n), 32'd8);
    rd(8'h20, v);
    chk("cnt_after_match", v, 32'd0);
    rd(8'h18, v);
    chk("reload_keeps_enable", v & 32'h101, 32'h101);
    wr(8'h18, 32'h0001_0105);
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      idle();
      if (timer_irq) n = i;
    end
    chk("oneshot_fired", 32'(n != 0), 32'd1);
    rd(8'h18, v);
    chk("oneshot_disables", v & 32'h101, 32'h100);

    rd(8'h40, v);
    chk("unmapped_data", v, 32'h0);
    chk("unmapped_error", 32'(bus.rsp_error), 32'h1);
    wr(8'h40, 32'hFFFF_FFFF);
    rd(8'h00, v);
    chk("unmapped_write_ignored", v, 32'h3);

    for (int i = 0; i < 400; i++) begin
      int r;
      logic [31:0] dat;
      if ($urandom_range(0, 7) == 0) gpio_in = ~gpio_in;
      r = $urandom_range(0, 11);
      case (r)
        6:       dat = $urandom & 32'h0003_0107;
        7, 8:    dat = $urandom_range(0, 6);
        default: dat = $urandom;
      endcase
      if ($urandom_range(0, 2) == 0) begin
        bus.cmd_valid = 1'b0;
      end else begin
        bus.cmd_valid = 1'b1;
        bus.cmd_wr = $urandom_range(0, 1) == 1;
        bus.cmd_addr = {6'(r), 2'($urandom_range(0, 3))};
        bus.cmd_size = 2'($urandom_range(0, 3));
        bus.cmd_data = dat;
      end
      step();
    end
    bus.cmd_valid = 1'b0;

    wr(8'h1C, 32'd5);
    wr(8'h18, 32'h0000_0001);
    repeat (3) idle();
    bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b0; bus.cmd_addr = 8'h24; bus.cmd_size = 2'd2;
    #3;
    reset = 1'b1;
    m_reset();
    @(posedge clk); #1;
    chk("reset_kills_read", 32'(bus.rsp_ready), 32'h0);
    chk("reset_mid_gpio_out", 32'(gpio_out), 32'h7);
    chk("reset_mid_irqs", {30'd0, timer_irq, gpio_irq}, 32'h0);
    bus.cmd_valid = 1'b0;
    reset = 1'b0;
    rd(8'h20, v);
    chk("reset_cnt", v, 32'h0);
    rd(8'h18, v);
    chk("reset_ctrl", v, 32'h0);
    rd(8'h00, v);
    chk("reset_out", v, 32'h0);
    repeat (4) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dbus_gpio_timer.md
# dbus_gpio_timer

Parametrised peripheral slave for the VexRiscv simple dBus, generalising the fixed LED/status register pair into N-bit GPIO output and input banks with edge capture, plus a compare-match timer with prescaler and interrupt outputs. It sits behind the top-level dBus address decoder in the peripheral window. It returns read data with fixed one-cycle latency, so it merges into the existing rsp mux unchanged. `timer_irq` and `gpio_irq` feed the CPU interrupt inputs.

## Interface
- NUM_OUT, 3 — GPIO output count, 1..32
- NUM_IN, 1 — GPIO input count, 1..32
- OUT_INVERT, 3'b111 — per-bit pin polarity; pin = logical XOR OUT_INVERT (LEDs active-low)
- OUT_RESET, 0 — logical OUT value at reset
- TIMER_BITS, 32 — counter/compare width, 1..32
- SIM_FLAG, 0 — value reported in ID[0]
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  access; already qualified by the external window decode
- cmd_ready  out  1  tied 1; no wait states
- cmd_wr  in  1  1 = write
- cmd_addr  in  8  byte offset in window; [7:2] selects register
- cmd_data  in  32  write data
- cmd_size  in  2  0 = byte, 1 = half, 2 = word
- rsp_ready  out  1  read data valid
- rsp_error  out  1  unmapped read
- rsp_data  out  32  read data
- gpio_out  out  NUM_OUT  pins
- gpio_in  in  NUM_IN  asynchronous inputs
- timer_irq  out  1  timer interrupt, level
- gpio_irq  out  1  GPIO interrupt, level

## Operation
- Byte enables: size 0 -> 4'b0001<<addr[1:0]; size 1 -> 4'b0011<<addr[1:0]; else 4'b1111. Writes update enabled bytes only. For W1S/W1C registers, disabled bytes count as 0.
- Register map (byte offset). Bits above the implemented width read 0.
  - 0x00 OUT: RW, logical value.
  - 0x04 OUT_SET: W1S on OUT; reads 0.
  - 0x08 OUT_CLR: W1C on OUT; reads 0.
  - 0x0C IN: RO, 2-FF synchronised gpio_in.
  - 0x10 IN_RISE: sticky rising-edge flags on the synchronised value; W1C.
  - 0x14 IN_IRQ_EN: RW mask.
  - 0x18 TIMER_CTRL: [0] enable, [1] auto-reload, [2] irq enable, [8] pending (W1C; write 0 no effect), [23:16] prescale P; other bits 0.
  - 0x1C TIMER_CMP: RW.
  - 0x20 TIMER_CNT: RW; write loads count.
  - 0x24 ID: RO {NUM_OUT[7:0], NUM_IN[7:0], TIMER_BITS[7:0], 7'b0, SIM_FLAG}.
- Unmapped offsets:
  - Reads return rsp_data = 0, rsp_error = 1.
  - Writes are ignored silently.
- Edge detect: previous-sample register plus primed flag, both cleared by reset. The first synchronised sample after reset loads previous without flagging. Thereafter a 0->1 transition sets IN_RISE.
- Timer:
  - When enable = 1, the prescaler counts 0..P; a tick occurs when it equals P, then it wraps to 0. The prescaler is held at 0 while disabled.
  - On a tick with CNT == CMP: set pending; CNT <= 0; if auto-reload = 0, clear enable.
  - On a tick otherwise: CNT <= CNT+1, modulo 2^TIMER_BITS.
- gpio_irq = |(IN_RISE & IN_IRQ_EN). timer_irq = pending & irq enable.
- Simultaneous events:
  - A hardware set (edge, match) beats a same-cycle W1C.
  - A CPU write to CNT beats a same-cycle tick increment or reload. Pending still sets if the pre-write CNT == CMP on that tick.
  - A write to OUT with a same-cycle SET/CLR is impossible (single port).

## Timing
- Reads: rsp_ready = 1 exactly the cycle after cmd_valid & !cmd_wr, otherwise 0. rsp_data and rsp_error are valid in that cycle and reflect register state before any same-cycle update. Reads have no side effects.
- Writes: register takes the new value the cycle after the command. gpio_out and irq outputs are registered and change that same cycle.
- Input path: a gpio_in edge reaches IN after 2 cycles and IN_RISE/gpio_irq after 3 cycles.
- Timer: with P = 0 it ticks every enabled cycle. Match-to-pending is 1 cycle; timer_irq asserts the same cycle as pending.
- Reset (async, any time, including mid-transaction):
  - OUT = OUT_RESET, so gpio_out = OUT_RESET ^ OUT_INVERT.
  - rsp_ready, rsp_error, rsp_data, irqs, sync FFs, IN_RISE, IN_IRQ_EN, CTRL, CMP, CNT and prescaler are all 0.
  - A read accepted the cycle reset asserts produces no response.

## Test plan
- Reset, then read 0x24 with defaults -> rsp_ready one cycle later, rsp_data = 0x03012000, rsp_error = 0; gpio_out = 3'b111.
- Write OUT = 0x5, then OUT_CLR = 0x4, then OUT_SET = 0x2, then read OUT -> reads 0x3, gpio_out = 3'b100. Byte write 0xFF to offset 0x01 leaves OUT = 0x3.
- Raise gpio_in[0] -> IN_RISE[0] set 3 cycles later; gpio_irq = 1 only after IN_IRQ_EN = 1. W1C in the same cycle as a new edge -> flag stays 1.
- CMP = 3, P = 1, CTRL = 0x7 -> pending/timer_irq set 8 cycles after enable, CNT = 0, timer continues. With auto-reload = 0 -> enable reads 0 after match.
- Read offset 0x40 -> rsp_data = 0, rsp_error = 1. Write to 0x40 -> no state change.
- Assert reset mid-count and in the cycle of a read command -> no rsp_ready, all registers at reset values.
